// File: rtl/fma_writeback_buffer_if.sv
// fma_writeback_buffer_if: FMA result capture side and data-cache beat side of the writeback buffer.
// Carries wb_mask_in only when FMA_WB_MASK_EN is defined.
interface fma_writeback_buffer_if #(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH = 16
);
  localparam int IDX_W = FMA_COUNT > 1 ? $clog2(FMA_COUNT) : 1;
  logic [FMA_COUNT-1:0][WIDTH-1:0] c_in;
  logic c_valid_in;
  logic ready_out;
  logic [WIDTH-1:0] data_out;
  logic [IDX_W-1:0] index_out;
  logic data_valid_out;
  logic data_ready_in;
  logic overflow_out;
`ifdef FMA_WB_MASK_EN
  logic [FMA_COUNT-1:0] wb_mask_in;
  modport master (output c_in, c_valid_in, data_ready_in, wb_mask_in,
                  input ready_out, data_out, index_out, data_valid_out, overflow_out);
  modport slave (input c_in, c_valid_in, data_ready_in, wb_mask_in,
                 output ready_out, data_out, index_out, data_valid_out, overflow_out);
`else
  modport master (output c_in, c_valid_in, data_ready_in,
                  input ready_out, data_out, index_out, data_valid_out, overflow_out);
  modport slave (input c_in, c_valid_in, data_ready_in,
                 output ready_out, data_out, index_out, data_valid_out, overflow_out);
`endif
endinterface

// File: rtl/fma_writeback_buffer.sv
// fma_writeback_buffer: captures a parallel set of FMA results and drains it one lane per beat.
// Define FMA_WB_MASK_EN to emit only the lanes selected by wb_mask_in.
module fma_writeback_buffer #(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH = 16
) (
  input logic clk_in,
  input logic rst_n_in,
  fma_writeback_buffer_if.slave bus
);
  localparam int IDX_W = FMA_COUNT > 1 ? $clog2(FMA_COUNT) : 1;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;
  logic [FMA_COUNT-1:0][WIDTH-1:0] lanes;
  logic [WIDTH-1:0] data;
  logic [IDX_W-1:0] idx, nxt, first;
  logic dv, ovf, last, ready, cap, drop;
  logic [FMA_COUNT-1:0] act, m_new;
`ifdef FMA_WB_MASK_EN
  logic [FMA_COUNT-1:0] mask_r;
  assign act = mask_r;
  assign m_new = bus.wb_mask_in;
`else
  assign act = '1;
  assign m_new = '1;
`endif
  // nxt is the lowest active lane above idx; none means idx is the last lane
  always_comb begin
    nxt = idx;
    last = 1'b1;
    first = '0;
    for (int i = FMA_COUNT - 1; i >= 0; i--) begin
      if (act[i] && i > int'(idx)) begin
        nxt = IDX_W'(i);
        last = 1'b0;
      end
      if (m_new[i]) first = IDX_W'(i);
    end
  end
  assign ready = state == IDLE || (last && bus.data_ready_in);
  assign cap = bus.c_valid_in && ready && |m_new;
  assign drop = bus.c_valid_in && !ready && |m_new;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      lanes <= '0;
      data <= '0;
      idx <= '0;
      dv <= 1'b0;
      ovf <= 1'b0;
`ifdef FMA_WB_MASK_EN
      mask_r <= '0;
`endif
    end else begin
      if (drop) ovf <= 1'b1;
      if (cap) begin
        lanes <= bus.c_in;
`ifdef FMA_WB_MASK_EN
        mask_r <= m_new;
`endif
        idx <= first;
        data <= bus.c_in[first];
        dv <= 1'b1;
        state <= DRAIN;
      end else if (state == DRAIN && bus.data_ready_in) begin
        if (last) begin
          dv <= 1'b0;
          state <= IDLE;
        end else begin
          idx <= nxt;
          data <= lanes[nxt];
        end
      end
    end
  end
  assign bus.ready_out = ready;
  assign bus.data_out = data;
  assign bus.index_out = idx;
  assign bus.data_valid_out = dv;
  assign bus.overflow_out = ovf;
endmodule

// File: tb/tb_fma_writeback_buffer.sv
// tb_fma_writeback_buffer: directed checks of capture, drain, backpressure, overflow and reset.
// With FMA_WB_MASK_EN defined it runs with four lanes and also exercises masking.
module tb_fma_writeback_buffer;
`ifdef FMA_WB_MASK_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  fma_writeback_buffer_if #(.FMA_COUNT(N), .WIDTH(16)) bus ();
  fma_writeback_buffer #(.FMA_COUNT(N), .WIDTH(16)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set2(input logic [15:0] a1, input logic [15:0] a0);
    bus.c_in = '0;
    bus.c_in[1] = a1;
    bus.c_in[0] = a0;
`ifdef FMA_WB_MASK_EN
    bus.wb_mask_in = 4'b0011;
`endif
  endtask
  task automatic beat(input string tag, input logic [31:0] i, input logic [15:0] d);
    chk({tag, ".v"}, 32'(bus.data_valid_out), 1);
    chk({tag, ".i"}, 32'(bus.index_out), i);
    chk({tag, ".d"}, 32'(bus.data_out), 32'(d));
  endtask
  initial begin
    bus.c_valid_in = 1'b0;
    bus.data_ready_in = 1'b0;
    set2(16'h0, 16'h0);
    #12;
    chk("rst.v", 32'(bus.data_valid_out), 0);
    chk("rst.d", 32'(bus.data_out), 0);
    chk("rst.i", 32'(bus.index_out), 0);
    chk("rst.o", 32'(bus.overflow_out), 0);
    chk("rst.r", 32'(bus.ready_out), 1);
    tick();
    rst_n = 1'b1;
    // basic drain
    bus.data_ready_in = 1'b1;
    set2(16'h1234, 16'hABCD);
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    beat("b0", 0, 16'hABCD);
    chk("b0.r", 32'(bus.ready_out), 0);
    tick();
    beat("b1", 1, 16'h1234);
    chk("b1.r", 32'(bus.ready_out), 1);
    tick();
    chk("bend.v", 32'(bus.data_valid_out), 0);
    chk("bend.r", 32'(bus.ready_out), 1);
    // backpressure
    bus.data_ready_in = 1'b0;
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    beat("bp0", 0, 16'hABCD);
    for (int k = 0; k < 3; k++) begin
      tick();
      beat("bp_hold", 0, 16'hABCD);
      chk("bp_hold.r", 32'(bus.ready_out), 0);
    end
    bus.data_ready_in = 1'b1;
    tick();
    beat("bp1", 1, 16'h1234);
    tick();
    chk("bpend.v", 32'(bus.data_valid_out), 0);
    // back-to-back
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    beat("bb0", 0, 16'hABCD);
    tick();
    beat("bb1", 1, 16'h1234);
    set2(16'h0002, 16'h0001);
    bus.c_valid_in = 1'b1;
    chk("bb.r", 32'(bus.ready_out), 1);
    tick();
    bus.c_valid_in = 1'b0;
    beat("bb2", 0, 16'h0001);
    chk("bb.o", 32'(bus.overflow_out), 0);
    tick();
    beat("bb3", 1, 16'h0002);
    tick();
    chk("bbend.v", 32'(bus.data_valid_out), 0);
    // overflow while stalled
    bus.data_ready_in = 1'b0;
    set2(16'h1234, 16'hABCD);
    bus.c_valid_in = 1'b1;
    tick();
    set2(16'hFFFF, 16'hEEEE);
    chk("ov.r", 32'(bus.ready_out), 0);
    tick();
    bus.c_valid_in = 1'b0;
    chk("ov.o", 32'(bus.overflow_out), 1);
    beat("ov0", 0, 16'hABCD);
    bus.data_ready_in = 1'b1;
    tick();
    beat("ov1", 1, 16'h1234);
    tick();
    chk("ovend.v", 32'(bus.data_valid_out), 0);
    chk("ovend.o", 32'(bus.overflow_out), 1);
    // reset mid-drain
    bus.data_ready_in = 1'b0;
    set2(16'h1234, 16'hABCD);
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    beat("rm0", 0, 16'hABCD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm.v", 32'(bus.data_valid_out), 0);
    chk("rm.o", 32'(bus.overflow_out), 0);
    chk("rm.d", 32'(bus.data_out), 0);
    tick();
    rst_n = 1'b1;
    bus.data_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_after.v", 32'(bus.data_valid_out), 0);
    end
`ifdef FMA_WB_MASK_EN
    bus.c_in[0] = 16'h000A;
    bus.c_in[1] = 16'h000B;
    bus.c_in[2] = 16'h000C;
    bus.c_in[3] = 16'h000D;
    bus.wb_mask_in = 4'b1010;
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    beat("mk0", 1, 16'h000B);
    tick();
    beat("mk1", 3, 16'h000D);
    tick();
    chk("mkend.v", 32'(bus.data_valid_out), 0);
    bus.wb_mask_in = 4'b0000;
    bus.c_valid_in = 1'b1;
    tick();
    bus.c_valid_in = 1'b0;
    chk("mz.v", 32'(bus.data_valid_out), 0);
    chk("mz.r", 32'(bus.ready_out), 1);
    chk("mz.o", 32'(bus.overflow_out), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fma_writeback_buffer.md
FMA_WRITEBACK_BUFFER -- requirements
Module: fma_writeback_buffer

Interface
REQ-001 SHALL have parameter FMA_COUNT, default 2: number of FMA result lanes captured in parallel.
REQ-002 SHALL have parameter WIDTH, default 16: bits per fixed-point result.
REQ-003 SHALL define local IDX_W = max(1, clog2(FMA_COUNT)).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk_in  input  1  sole clock; all logic on the rising edge.
REQ-006 rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 c_in  input  array [FMA_COUNT-1:0] of WIDTH  FMA results; lane i is the result of FMA i.
REQ-008 c_valid_in  input  1  one-cycle pulse; all lanes of c_in are valid.
REQ-009 ready_out  output  1  buffer can accept c_valid_in this cycle.
REQ-010 data_out  output  WIDTH  current result beat to the data cache.
REQ-011 index_out  output  IDX_W  FMA lane number of data_out.
REQ-012 data_valid_out  output  1  data_out/index_out are valid.
REQ-013 data_ready_in  input  1  data cache accepts the beat; a transfer occurs when data_valid_out && data_ready_in.
REQ-014 overflow_out  output  1  sticky: a result set was dropped.

Function
REQ-015 SHALL implement FSM states IDLE and DRAIN.
REQ-016 IDLE, c_valid_in high: SHALL capture all c_in lanes, load data_out with lane 0, set index_out=0 and data_valid_out=1, and enter DRAIN. The first beat is visible the cycle after capture.
REQ-017 DRAIN: data_out, index_out and data_valid_out SHALL hold stable while data_ready_in is low.
REQ-018 DRAIN, transfer on lane k < FMA_COUNT-1: next cycle SHALL present lane k+1.
REQ-019 DRAIN, transfer on the last lane, c_valid_in low: SHALL drop data_valid_out and return to IDLE.
REQ-020 DRAIN, transfer on the last lane, c_valid_in high in the same cycle: SHALL capture the new set, present its lane 0 the next cycle, and stay in DRAIN. No bubble occurs.
REQ-021 ready_out SHALL be combinational: (state==IDLE) || (DRAIN && last lane && data_ready_in).
REQ-022 c_valid_in while ready_out low: SHALL ignore the set, leave the in-flight drain undisturbed, and set overflow_out=1 until reset.
REQ-023 Beats SHALL be emitted in ascending lane order. Each captured lane SHALL be emitted exactly once.
REQ-024 FMA_COUNT=1: every set SHALL be a single beat with index_out=0.

Reset
REQ-025 While rst_n_in is low: state=IDLE, data_out=0, index_out=0, data_valid_out=0, overflow_out=0, stored lanes=0, ready_out=1.
REQ-026 Reset asserted mid-drain SHALL immediately abort the drain and discard the remaining beats. The next valid beat SHALL appear only after a new capture.

Configuration
REQ-027 Macro FMA_WB_MASK_EN SHALL control lane masking.
REQ-028 FMA_WB_MASK_EN defined: SHALL add input wb_mask_in [FMA_COUNT-1:0], captured together with c_in.
REQ-029 FMA_WB_MASK_EN defined: only lanes whose mask bit is set SHALL be emitted, in ascending order.
REQ-030 FMA_WB_MASK_EN defined: "last lane" in REQ-019 to REQ-021 SHALL mean the highest set mask bit.
REQ-031 FMA_WB_MASK_EN defined: a capture with an all-zero mask SHALL be a no-op (no state change, no overflow, no beat).
REQ-032 FMA_WB_MASK_EN undefined: the port SHALL be absent and all lanes SHALL be emitted.

Verification
REQ-033 Basic drain: FMA_COUNT=2, c_in={0x1234 (lane1), 0xABCD (lane0)}, data_ready_in held 1 -> beats (idx0,0xABCD) then (idx1,0x1234) on consecutive cycles; data_valid_out low afterwards; ready_out=1.
REQ-034 Backpressure: same stimulus with data_ready_in low for 3 cycles after the first beat -> (idx0,0xABCD) held stable for 4 cycles, then idx1 is delivered.
REQ-035 Back-to-back: second c_valid_in with lanes {0x0002, 0x0001} coincides with the last-lane transfer -> next cycle presents (idx0,0x0001) with no idle cycle; overflow_out stays 0.
REQ-036 Overflow: c_valid_in while idx0 is stalled -> overflow_out=1 and stays 1; the original beats are unchanged.
REQ-037 Reset mid-drain: assert rst_n_in after the first beat -> data_valid_out=0 asynchronously; no idx1 beat after release.
REQ-038 FMA_WB_MASK_EN, FMA_COUNT=4, mask=4'b1010 -> only idx1 and idx3 are emitted. A capture with mask=0 -> no beat, ready_out stays 1.
